bb_grader_multi: RTL and testbench
==================================

BB_GRADER_MULTI -- requirements
Module: bb_grader_multi

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: digits per answer and question, range 2..8.
REQ-002 SHALL have parameter DIGIT_W, default 4: bits per digit.
REQ-003 SHALL have parameter CNT_W, default 16: guess-counter width.
REQ-004 SHALL have parameter MAX_GUESS, default 200: guess limit per game; 0 means unlimited.
REQ-005 SHALL have parameter TIMEOUT, default 200: stall-cycle limit for the watchdog.
REQ-006 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-007 SHALL have port reset, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port answer_load, input, 1: one-cycle strobe that loads answer_in and starts a game.
REQ-009 SHALL have port answer_in, input, NUM_DIGITS*DIGIT_W: secret; digit 0 in the MS bits.
REQ-010 SHALL have ports ask_valid (input, 1), ask_ready (output, 1) and question (input, NUM_DIGITS*DIGIT_W): the guess channel.
REQ-011 SHALL have ports reply_valid (output, 1) and reply_ready (input, 1): the result channel.
REQ-012 SHALL have ports strike and ball, outputs, $clog2(NUM_DIGITS+1) each: scores.
REQ-013 SHALL have port correct, output, 1: all digits are strikes.
REQ-014 SHALL have ports guess_cnt (output, CNT_W), game_over (output, 1) and timeout (output, 1): status.

Function
REQ-015 SHALL implement FSM IDLE/PLAY/DONE: IDLE->PLAY on answer_load; answer_load from any state reloads the answer, clears guess_cnt, game_over and timeout, and enters PLAY.
REQ-016 SHALL drive ask_ready=1 only in PLAY, with answer_load=0, and with the reply register empty or draining this cycle (reply_valid & reply_ready).
REQ-017 SHALL accept a guess on ask_valid & ask_ready and present the registered score one cycle later with reply_valid=1.
REQ-018 SHALL score digit i a strike if question[i]==answer[i], else a ball if question[i]==answer[j] for any j!=i; each question digit is scored independently, so duplicates may each score.
REQ-019 SHALL set correct=1 iff strike==NUM_DIGITS.
REQ-020 SHALL hold strike, ball, correct and reply_valid stable while reply_valid & !reply_ready.
REQ-021 SHALL increment guess_cnt on each accepted guess and saturate it at 2^CNT_W-1.
REQ-022 SHALL move to DONE after the handshake of a correct reply.
REQ-023 SHALL, for a non-correct reply with MAX_GUESS!=0 and guess_cnt==MAX_GUESS, set game_over=1 and move to DONE after that reply's handshake.
REQ-024 SHALL give answer_load priority over a same-cycle ask: the guess is not accepted, and any pending reply is discarded (reply_valid=0 next cycle).
REQ-025 SHALL keep ask_ready=0 in DONE and IDLE; reply_valid SHALL still drain normally.

Reset
REQ-026 SHALL, on reset=0 at a clock edge, set state=IDLE, ask_ready=0, reply_valid=0, strike=0, ball=0, correct=0, guess_cnt=0, game_over=0, timeout=0 and answer register=0.
REQ-027 SHALL treat reset mid-game as abandoning the game, with no reply emitted.

Configuration
REQ-028 SHALL, with macro BB_GRADER_TIMEOUT_EN defined, count PLAY cycles with no handshake on either channel, clear the count on any handshake, and, on reaching TIMEOUT, set sticky timeout=1 and enter DONE.
REQ-029 SHALL, without BB_GRADER_TIMEOUT_EN, omit the counter and tie timeout to 0.

Structure
REQ-030 SHALL place the FSM state enum and the score-width function in shared package bb_pkg.
REQ-031 SHALL implement the combinational per-digit strike/ball compare and popcount in sub-module bb_score, instantiated once.

Verification
REQ-032 SHALL cover: answer 0x1234, ask 0x1234 -> next cycle reply_valid=1, strike=4, ball=0, correct=1; state DONE after handshake.
REQ-033 SHALL cover: answer 0x1234, ask 0x4321 -> strike=0, ball=4; ask 0x1356 -> strike=1, ball=1, guess_cnt=2.
REQ-034 SHALL cover: reply_ready=0 for 5 cycles -> reply fields stable and ask_ready=0; a new guess is accepted in the same cycle reply_ready rises.
REQ-035 SHALL cover: MAX_GUESS=3 with three wrong guesses -> game_over=1 after the third handshake, and ask_ready stays 0.
REQ-036 SHALL cover: answer_load with ask_valid and a pending reply -> reply_valid=0 next cycle, guess_cnt=0, and the guess is not counted.
REQ-037 SHALL cover, with BB_GRADER_TIMEOUT_EN and TIMEOUT=200: 200 idle PLAY cycles -> timeout=1 and state DONE; without the macro -> timeout stays 0.

Source files
------------

// File: rtl/bb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bb_pkg                                                                |
// | Shared FSM state encoding and score-width helper for the grader.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package bb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } bb_state_t;

  // Bits needed to hold a count of 0..n matching digits.
  function automatic int score_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bb_score.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bb_score                                                              |
// | Combinational per-digit strike/ball compare and popcount.             |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module bb_score
  import bb_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
) (
  input  logic [NUM_DIGITS*DIGIT_W-1:0]     answer,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]     question,
  output logic [score_w(NUM_DIGITS)-1:0]    strike,
  output logic [score_w(NUM_DIGITS)-1:0]    ball
);

  localparam int SW = score_w(NUM_DIGITS);

  logic [NUM_DIGITS-1:0] hit_s;
  logic [NUM_DIGITS-1:0] hit_b;

  // Digit 0 lives in the most significant bits of each vector.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    localparam logic [NUM_DIGITS-1:0] SELF = NUM_DIGITS'(1) << i;
    logic [DIGIT_W-1:0]    q_d;
    logic [NUM_DIGITS-1:0] eq;

    assign q_d = question[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W];

    for (genvar j = 0; j < NUM_DIGITS; j++) begin : g_cmp
      assign eq[j] = (q_d == answer[(NUM_DIGITS-1-j)*DIGIT_W +: DIGIT_W]);
    end

    assign hit_s[i] = eq[i];
    assign hit_b[i] = !eq[i] && |(eq & ~SELF);
  end

  always_comb begin
    strike = '0;
    ball   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      strike = strike + SW'(hit_s[k]);
      ball   = ball   + SW'(hit_b[k]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bb_grader_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bb_grader_multi                                                       |
// | Multi-guess bulls-and-cows grader with ready/valid guess and reply    |
// | channels. Optional stall watchdog: define BB_GRADER_TIMEOUT_EN.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module bb_grader_multi
  import bb_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter int CNT_W      = 16,
  parameter int MAX_GUESS  = 200,
  parameter int TIMEOUT    = 200
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           answer_load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]  answer_in,
  input  logic                           ask_valid,
  output logic                           ask_ready,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]  question,
  output logic                           reply_valid,
  input  logic                           reply_ready,
  output logic [score_w(NUM_DIGITS)-1:0] strike,
  output logic [score_w(NUM_DIGITS)-1:0] ball,
  output logic                           correct,
  output logic [CNT_W-1:0]               guess_cnt,
  output logic                           game_over,
  output logic                           timeout
);

  localparam int SW = score_w(NUM_DIGITS);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || TIMEOUT < 1) begin : g_param_check
    $error("bb_grader_multi: NUM_DIGITS must be 2..8 and TIMEOUT at least 1");
  end

  bb_state_t                     state;
  logic [NUM_DIGITS*DIGIT_W-1:0] answer;
  logic [SW-1:0]                 sc_strike;
  logic [SW-1:0]                 sc_ball;
  logic                          accept;
  logic                          drain;
  logic                          limit_hit;
  logic                          last_pending;
  logic                          wd_expire;

  bb_score #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W)
  ) u_score (
    .answer   (answer),
    .question (question),
    .strike   (sc_strike),
    .ball     (sc_ball)
  );

  assign limit_hit    = (MAX_GUESS != 0) && (guess_cnt == CNT_W'(MAX_GUESS));
  assign last_pending = correct || limit_hit;
  assign drain        = reply_valid && reply_ready;
  // A reply that ends the game blocks further guesses even while it drains.
  assign ask_ready    = (state == S_PLAY) && !answer_load &&
                        (!reply_valid || (reply_ready && !last_pending));
  assign accept       = ask_valid && ask_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      answer      <= '0;
      reply_valid <= 1'b0;
      strike      <= '0;
      ball        <= '0;
      correct     <= 1'b0;
      guess_cnt   <= '0;
      game_over   <= 1'b0;
    end else if (answer_load) begin
      state       <= S_PLAY;
      answer      <= answer_in;
      reply_valid <= 1'b0;
      guess_cnt   <= '0;
      game_over   <= 1'b0;
    end else begin
      if (accept) begin
        reply_valid <= 1'b1;
        strike      <= sc_strike;
        ball        <= sc_ball;
        correct     <= (sc_strike == SW'(NUM_DIGITS));
        if (guess_cnt != {CNT_W{1'b1}}) begin
          guess_cnt <= guess_cnt + 1'b1;
        end
      end else if (drain) begin
        reply_valid <= 1'b0;
      end

      if (drain && state == S_PLAY) begin
        if (correct) begin
          state <= S_DONE;
        end else if (limit_hit) begin
          game_over <= 1'b1;
          state     <= S_DONE;
        end
      end

      if (wd_expire) begin
        state <= S_DONE;
      end
    end
  end

`ifdef BB_GRADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_cnt;
  logic          timeout_r;
  logic          idle_cycle;

  assign idle_cycle = (state == S_PLAY) && !accept && !drain;
  assign wd_expire  = idle_cycle && (idle_cnt == TW'(TIMEOUT - 1));
  assign timeout    = timeout_r;

  always_ff @(posedge clk) begin
    if (!reset || answer_load) begin
      idle_cnt  <= '0;
      timeout_r <= 1'b0;
    end else if (wd_expire) begin
      idle_cnt  <= '0;
      timeout_r <= 1'b1;
    end else if (idle_cycle) begin
      idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bb_grader_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bb_grader_multi                                                    |
// | Self-checking bench: vector table, directed sequences, random games.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_bb_grader_multi;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int CW = 16;
  localparam int MG = 3;
  localparam int TO = 200;
  localparam int SW = $clog2(N + 1);

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            answer_load = 1'b0;
  logic [N*DW-1:0] answer_in = '0;
  logic            ask_valid = 1'b0;
  logic            ask_ready;
  logic [N*DW-1:0] question = '0;
  logic            reply_valid;
  logic            reply_ready = 1'b1;
  logic [SW-1:0]   strike;
  logic [SW-1:0]   ball;
  logic            correct;
  logic [CW-1:0]   guess_cnt;
  logic            game_over;
  logic            timeout;

  int checks = 0;
  int errors = 0;

  bb_grader_multi #(
    .NUM_DIGITS (N),
    .DIGIT_W    (DW),
    .CNT_W      (CW),
    .MAX_GUESS  (MG),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .answer_load (answer_load),
    .answer_in   (answer_in),
    .ask_valid   (ask_valid),
    .ask_ready   (ask_ready),
    .question    (question),
    .reply_valid (reply_valid),
    .reply_ready (reply_ready),
    .strike      (strike),
    .ball        (ball),
    .correct     (correct),
    .guess_cnt   (guess_cnt),
    .game_over   (game_over),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ans;
    logic [15:0] q;
    int          s;
    int          b;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference scoring straight from the game rules on digit arrays.
  task automatic model_score(input logic [15:0] ans, input logic [15:0] q,
                             output int s, output int b);
    int a_d[N];
    int q_d[N];
    s = 0;
    b = 0;
    for (int i = 0; i < N; i++) begin
      a_d[i] = int'(ans[(N-1-i)*DW +: DW]);
      q_d[i] = int'(q[(N-1-i)*DW +: DW]);
    end
    for (int i = 0; i < N; i++) begin
      if (q_d[i] == a_d[i]) begin
        s++;
      end else begin
        for (int j = 0; j < N; j++) begin
          if (j != i && q_d[i] == a_d[j]) begin
            b++;
            break;
          end
        end
      end
    end
  endtask

  task automatic load(input logic [15:0] ans);
    answer_load = 1'b1;
    answer_in   = ans;
    step();
    answer_load = 1'b0;
  endtask

  task automatic ask(input logic [15:0] q);
    int n;
    n = 0;
    ask_valid = 1'b1;
    question  = q;
    #1;
    while (!ask_ready && n < 20) begin
      step();
      n++;
    end
    if (!ask_ready) begin
      chk("ask_ready_wait", 32'(ask_ready), 32'd1);
      ask_valid = 1'b0;
    end else begin
      step();
      ask_valid = 1'b0;
    end
  endtask

  // Ask, optionally hold the reply for some cycles, check it, then drain.
  task automatic guess(input logic [15:0] q, input int es, input int eb, input int stall);
    reply_ready = (stall == 0);
    ask(q);
    for (int k = 0; k < stall; k++) begin
      step();
    end
    chk("reply_valid", 32'(reply_valid), 32'd1);
    chk("strike", 32'(strike), 32'(es));
    chk("ball", 32'(ball), 32'(eb));
    chk("correct", 32'(correct), 32'(es == N));
    reply_ready = 1'b1;
    step();
    chk("reply_drained", 32'(reply_valid), 32'd0);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{16'h1234, 16'h1234, 4, 0};
    tbl[1] = '{16'h1234, 16'h4321, 0, 4};
    tbl[2] = '{16'h1234, 16'h1356, 1, 1};
    tbl[3] = '{16'h1234, 16'h1111, 1, 3};
    tbl[4] = '{16'h1234, 16'h5678, 0, 0};
    tbl[5] = '{16'h1234, 16'h2143, 0, 4};
    tbl[6] = '{16'h1234, 16'h1243, 2, 2};
    tbl[7] = '{16'h1122, 16'h2211, 0, 4};
    tbl[8] = '{16'h1122, 16'h1212, 2, 2};
    tbl[9] = '{16'h00F0, 16'hF000, 2, 2};

    // Reset state
    repeat (3) step();
    chk("rst_ask_ready", 32'(ask_ready), 32'd0);
    chk("rst_reply_valid", 32'(reply_valid), 32'd0);
    chk("rst_strike", 32'(strike), 32'd0);
    chk("rst_ball", 32'(ball), 32'd0);
    chk("rst_correct", 32'(correct), 32'd0);
    chk("rst_guess_cnt", 32'(guess_cnt), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b1;
    ask_valid = 1'b1;
    step();
    chk("idle_ask_ready", 32'(ask_ready), 32'd0);
    ask_valid = 1'b0;

    // Vector table
    for (int t = 0; t < 10; t++) begin
      load(tbl[t].ans);
      guess(tbl[t].q, tbl[t].s, tbl[t].b, 0);
      chk("tbl_guess_cnt", 32'(guess_cnt), 32'd1);
    end

    // Correct guess ends the game
    load(16'h1234);
    guess(16'h1234, 4, 0, 0);
    ask_valid = 1'b1;
    #1;
    chk("done_ask_ready", 32'(ask_ready), 32'd0);
    chk("done_game_over", 32'(game_over), 32'd0);
    ask_valid = 1'b0;
    step();

    // Two scored guesses in one game
    load(16'h1234);
    guess(16'h4321, 0, 4, 0);
    guess(16'h1356, 1, 1, 0);
    chk("two_guess_cnt", 32'(guess_cnt), 32'd2);

    // Back-pressure: reply held, then a new guess accepted as ready rises
    load(16'h1234);
    reply_ready = 1'b0;
    ask(16'h2135);
    ask_valid = 1'b1;
    question  = 16'h1243;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_ask_ready", 32'(ask_ready), 32'd0);
      chk("bp_reply_valid", 32'(reply_valid), 32'd1);
      chk("bp_strike", 32'(strike), 32'd1);
      chk("bp_ball", 32'(ball), 32'd2);
      step();
    end
    reply_ready = 1'b1;
    #1;
    chk("bp_ready_rise", 32'(ask_ready), 32'd1);
    step();
    ask_valid = 1'b0;
    chk("bp_new_valid", 32'(reply_valid), 32'd1);
    chk("bp_new_strike", 32'(strike), 32'd2);
    chk("bp_new_ball", 32'(ball), 32'd2);
    chk("bp_guess_cnt", 32'(guess_cnt), 32'd2);
    step();

    // Guess limit
    load(16'h1234);
    guess(16'h5678, 0, 0, 0);
    guess(16'h4321, 0, 4, 1);
    chk("lim_game_over_2", 32'(game_over), 32'd0);
    guess(16'h1243, 2, 2, 0);
    chk("lim_game_over_3", 32'(game_over), 32'd1);
    chk("lim_guess_cnt", 32'(guess_cnt), 32'd3);
    ask_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lim_ask_ready", 32'(ask_ready), 32'd0);
      step();
    end
    ask_valid = 1'b0;
    chk("lim_guess_cnt_hold", 32'(guess_cnt), 32'd3);

    // Load beats a same-cycle ask and discards the pending reply
    load(16'h1234);
    reply_ready = 1'b0;
    ask(16'h1356);
    chk("ld_pending", 32'(reply_valid), 32'd1);
    answer_load = 1'b1;
    answer_in   = 16'h5678;
    ask_valid   = 1'b1;
    question    = 16'h5678;
    #1;
    chk("ld_ask_ready", 32'(ask_ready), 32'd0);
    step();
    answer_load = 1'b0;
    ask_valid   = 1'b0;
    chk("ld_reply_valid", 32'(reply_valid), 32'd0);
    chk("ld_guess_cnt", 32'(guess_cnt), 32'd0);
    reply_ready = 1'b1;
    guess(16'h5678, 4, 0, 0);
    chk("ld_guess_cnt_after", 32'(guess_cnt), 32'd1);

    // Reset mid-game abandons the pending reply
    load(16'h1234);
    reply_ready = 1'b0;
    ask(16'h1111);
    reset = 1'b0;
    step();
    reset = 1'b1;
    reply_ready = 1'b1;
    chk("mrst_reply_valid", 32'(reply_valid), 32'd0);
    chk("mrst_guess_cnt", 32'(guess_cnt), 32'd0);
    ask_valid = 1'b1;
    #1;
    chk("mrst_ask_ready", 32'(ask_ready), 32'd0);
    ask_valid = 1'b0;
    step();

    // Stall watchdog
    load(16'h1234);
    repeat (TO - 1) step();
    chk("wd_before", 32'(timeout), 32'd0);
    step();
`ifdef BB_GRADER_TIMEOUT_EN
    chk("wd_timeout", 32'(timeout), 32'd1);
    chk("wd_done", 32'(ask_ready), 32'd0);
`else
    chk("wd_timeout", 32'(timeout), 32'd0);
    chk("wd_play", 32'(ask_ready), 32'd1);
`endif

    // Random games against the reference model
    for (int g = 0; g < 40; g++) begin
      logic [15:0] ans;
      int          cnt;
      bit          won;
      ans = '0;
      for (int i = 0; i < N; i++) begin
        ans[i*DW +: DW] = 4'($urandom_range(0, 7));
      end
      load(ans);
      cnt = 0;
      won = 1'b0;
      for (int k = 0; k < MG && !won; k++) begin
        logic [15:0] q;
        int          es;
        int          eb;
        q = '0;
        for (int i = 0; i < N; i++) begin
          q[i*DW +: DW] = 4'($urandom_range(0, 7));
        end
        if ($urandom_range(0, 3) == 0) q = ans;
        model_score(ans, q, es, eb);
        guess(q, es, eb, int'($urandom_range(0, 3)));
        cnt++;
        won = (es == N);
        chk("rnd_guess_cnt", 32'(guess_cnt), 32'(cnt));
      end
      chk("rnd_game_over", 32'(game_over), 32'(!won));
      ask_valid = 1'b1;
      #1;
      chk("rnd_end_ready", 32'(ask_ready), 32'd0);
      ask_valid = 1'b0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
